// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: requester IDs,
// FSM states and the starvation counter geometry.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_L    = 2'd3
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_SAT = 4'd15;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of cycles the fetch port has waited; flags when the
// wait has reached the override threshold.
module mem_arb_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CNT_SAT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign starved = (cnt_reg >= MAX_WAIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I), load/store (D) and the
// boot loader (L); one outstanding transaction, D > I with starvation override.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            boot_mode,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_we,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    input  logic            l_req,
    input  logic [AW-1:0]   l_addr,
    input  logic [DW/8-1:0] l_we,
    input  logic [DW-1:0]   l_wdata,
    output logic            l_gnt,
    output logic            l_rvalid,
    output logic            m_req,
    output logic [AW-1:0]   m_addr,
    output logic [DW/8-1:0] m_we,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            err
);

    state_t state_reg, state_next;
    owner_t owner_reg, owner_next;
    owner_t winner;
    logic   err_reg;
    logic   starved;

    mem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (i_req && !boot_mode),
        .clr     (i_gnt || !i_req || boot_mode),
        .starved (starved)
    );

    always_comb begin
        winner = OWN_NONE;
        if (boot_mode) begin
            if (l_req) winner = OWN_L;
        end else if (i_req && starved) begin
            winner = OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end else if (i_req) begin
            winner = OWN_I;
        end
    end

    // Outputs are qualified by reset so they fall to zero the moment reset asserts.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        l_gnt      = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        l_rvalid   = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;
        m_req      = 1'b0;
        m_addr     = '0;
        m_we       = '0;
        m_wdata    = '0;
        if (reset) begin
            case (state_reg)
                ST_IDLE: begin
                    case (winner)
                        OWN_I: begin
                            m_req  = 1'b1;
                            m_addr = i_addr;
                        end
                        OWN_D: begin
                            m_req   = 1'b1;
                            m_addr  = d_addr;
                            m_we    = d_we;
                            m_wdata = d_wdata;
                        end
                        OWN_L: begin
                            m_req   = 1'b1;
                            m_addr  = l_addr;
                            m_we    = l_we;
                            m_wdata = l_wdata;
                        end
                        default: ;
                    endcase
                    if ((winner != OWN_NONE) && m_gnt) begin
                        state_next = ST_WAIT;
                        owner_next = winner;
                        i_gnt      = (winner == OWN_I);
                        d_gnt      = (winner == OWN_D);
                        l_gnt      = (winner == OWN_L);
                    end
                end
                ST_WAIT: begin
                    if (m_rvalid) begin
                        state_next = ST_IDLE;
                        owner_next = OWN_NONE;
                        i_rvalid   = (owner_reg == OWN_I);
                        d_rvalid   = (owner_reg == OWN_D);
                        l_rvalid   = (owner_reg == OWN_L);
                        if (owner_reg == OWN_I) i_rdata = m_rdata;
                        if (owner_reg == OWN_D) d_rdata = m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_NONE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            if ((state_reg == ST_IDLE) && m_rvalid) err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk;
    logic          reset;
    logic          boot_mode;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_gnt, i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic [31:0]   d_addr;
    logic [3:0]    d_we;
    logic [31:0]   d_wdata;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          l_req;
    logic [31:0]   l_addr;
    logic [3:0]    l_we;
    logic [31:0]   l_wdata;
    logic          l_gnt, l_rvalid;
    logic          m_req;
    logic [31:0]   m_addr;
    logic [3:0]    m_we;
    logic [31:0]   m_wdata;
    logic          m_gnt, m_rvalid;
    logic [31:0]   m_rdata;
    logic          err;

    int tests;
    int fails;

    mem_port_arbiter #(
        .AW (AW), .DW (DW), .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk), .reset (reset), .boot_mode (boot_mode),
        .i_req (i_req), .i_addr (i_addr), .i_gnt (i_gnt), .i_rvalid (i_rvalid), .i_rdata (i_rdata),
        .d_req (d_req), .d_addr (d_addr), .d_we (d_we), .d_wdata (d_wdata),
        .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
        .l_req (l_req), .l_addr (l_addr), .l_we (l_we), .l_wdata (l_wdata),
        .l_gnt (l_gnt), .l_rvalid (l_rvalid),
        .m_req (m_req), .m_addr (m_addr), .m_we (m_we), .m_wdata (m_wdata),
        .m_gnt (m_gnt), .m_rvalid (m_rvalid), .m_rdata (m_rdata),
        .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; l_req = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mreq", {31'd0, m_req}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        bm, ir, dr, lr, mg;
        logic        mreq;
        logic [31:0] maddr;
        logic [3:0]  mwe;
        logic [31:0] mwdata;
        logic [2:0]  gnt;   // {i, d, l}
    } vec_t;

    vec_t vecs [10];

    // Reference model state for the randomized run
    bit          busy_m, rp, drop_i, drop_d, drop_l;
    int          own_m, wait_i, rcd, who, ntx;
    logic [2:0]  e_g, e_r;
    logic        e_mreq;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [3:0]  e_we;

    initial begin
        tests = 0; fails = 0;
        boot_mode = 0;
        i_addr = 32'h40; d_addr = 32'h100; d_we = 4'h3; d_wdata = 32'h1111_2222;
        l_addr = 32'h200; l_we = 4'hF; l_wdata = 32'h3333_4444;

        //           bm ir dr lr mg  mreq maddr         mwe   mwdata          gnt
        vecs[0] = '{0, 0, 0, 0, 1,  0, 32'h0,        4'h0, 32'h0,          3'b000};
        vecs[1] = '{0, 1, 0, 0, 1,  1, 32'h40,       4'h0, 32'h0,          3'b100};
        vecs[2] = '{0, 0, 1, 0, 1,  1, 32'h100,      4'h3, 32'h1111_2222,  3'b010};
        vecs[3] = '{0, 1, 1, 0, 1,  1, 32'h100,      4'h3, 32'h1111_2222,  3'b010};
        vecs[4] = '{0, 1, 1, 1, 0,  1, 32'h100,      4'h3, 32'h1111_2222,  3'b000};
        vecs[5] = '{0, 0, 0, 1, 1,  0, 32'h0,        4'h0, 32'h0,          3'b000};
        vecs[6] = '{1, 1, 1, 0, 1,  0, 32'h0,        4'h0, 32'h0,          3'b000};
        vecs[7] = '{1, 0, 0, 1, 1,  1, 32'h200,      4'hF, 32'h3333_4444,  3'b001};
        vecs[8] = '{1, 1, 1, 1, 1,  1, 32'h200,      4'hF, 32'h3333_4444,  3'b001};
        vecs[9] = '{1, 1, 1, 1, 0,  1, 32'h200,      4'hF, 32'h3333_4444,  3'b000};

        // Reset asserted with live requests: every output must stay quiet
        reset = 1'b0;
        d_req = 1; m_gnt = 1; m_rvalid = 1; i_req = 0; l_req = 0; m_rdata = 32'hAAAA_5555;
        #2;
        chk("rst_mreq_live", {31'd0, m_req}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_gnts", {29'd0, i_gnt, d_gnt, l_gnt}, 32'd0);
        chk("rst_rvalids", {29'd0, i_rvalid, d_rvalid, l_rvalid}, 32'd0);
        chk("rst_drdata", d_rdata, 32'd0);
        chk("rst_err0", {31'd0, err}, 32'd0);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Table: one-cycle arbitration decisions from IDLE, then completion
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            boot_mode = vecs[v].bm; i_req = vecs[v].ir; d_req = vecs[v].dr; l_req = vecs[v].lr;
            m_gnt = vecs[v].mg; m_rvalid = 0;
            #1;
            chk("vec_mreq", {31'd0, m_req}, {31'd0, vecs[v].mreq});
            chk("vec_maddr", m_addr, vecs[v].maddr);
            chk("vec_mwe", {28'd0, m_we}, {28'd0, vecs[v].mwe});
            chk("vec_mwdata", m_wdata, vecs[v].mwdata);
            chk("vec_gnt", {29'd0, i_gnt, d_gnt, l_gnt}, {29'd0, vecs[v].gnt});
            @(negedge clk);
            i_req = 0; d_req = 0; l_req = 0; m_gnt = 0;
            m_rvalid = |vecs[v].gnt; m_rdata = 32'hC0DE_0000 + v;
            #1;
            chk("vec_rvalid", {29'd0, i_rvalid, d_rvalid, l_rvalid}, {29'd0, vecs[v].gnt});
            $display("[TB] vec %0d bm=%0d req(i,d,l)=%0d%0d%0d mg=%0d gnt=%b", v,
                     vecs[v].bm, vecs[v].ir, vecs[v].dr, vecs[v].lr, vecs[v].mg, {i_gnt, d_gnt, l_gnt});
        end
        @(negedge clk);
        idle_inputs(); boot_mode = 0;
        #1;
        chk("vec_err", {31'd0, err}, 32'd0);

        // D write, response two cycles after the grant
        @(negedge clk);
        d_req = 1; d_addr = 32'h100; d_we = 4'hF; d_wdata = 32'hDEAD_BEEF; m_gnt = 1;
        #1;
        chk("dw_gnt", {31'd0, d_gnt}, 32'd1);
        chk("dw_mwe", {28'd0, m_we}, 32'hF);
        chk("dw_mwdata", m_wdata, 32'hDEAD_BEEF);
        chk("dw_ignt", {31'd0, i_gnt}, 32'd0);
        @(negedge clk);
        d_req = 0; m_gnt = 1;
        #1;
        chk("dw_wait_mreq", {31'd0, m_req}, 32'd0);
        chk("dw_wait_flags", {28'd0, i_gnt, d_gnt, d_rvalid, i_rvalid}, 32'd0);
        @(negedge clk);
        m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0;
        #1;
        chk("dw_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("dw_irvalid", {30'd0, i_rvalid, i_gnt}, 32'd0);
        @(negedge clk);
        m_rvalid = 0;
        #1;
        chk("dw_rvalid_off", {31'd0, d_rvalid}, 32'd0);
        $display("[TB] directed D write 0x100 done");

        // I read with combinational data pass-through
        @(negedge clk);
        i_req = 1; i_addr = 32'h40; m_gnt = 1;
        #1;
        chk("ir_gnt", {31'd0, i_gnt}, 32'd1);
        chk("ir_maddr", m_addr, 32'h40);
        chk("ir_mwe", {28'd0, m_we}, 32'd0);
        @(negedge clk);
        i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_0013;
        #1;
        chk("ir_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("ir_rdata", i_rdata, 32'h13);
        chk("ir_drvalid", {31'd0, d_rvalid}, 32'd0);
        chk("ir_drdata", d_rdata, 32'd0);
        @(negedge clk);
        m_rvalid = 0;
        $display("[TB] directed I read 0x40 done");

        // Starvation: I and D held, latency 1 -> D, D, then I overrides
        begin
            int exp_g [7];
            exp_g = '{2, 0, 2, 0, 1, 0, 2};
            i_addr = 32'h80; d_addr = 32'h300; d_we = 4'h0;
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                i_req = 1; d_req = 1; m_gnt = 1;
                m_rvalid = (c % 2 == 1); m_rdata = 32'h5000 + c;
                #1;
                chk("st_ignt", {31'd0, i_gnt}, {31'd0, exp_g[c] == 1});
                chk("st_dgnt", {31'd0, d_gnt}, {31'd0, exp_g[c] == 2});
                if (exp_g[c] == 1) chk("st_maddr", m_addr, 32'h80);
                if (c == 5) chk("st_irvalid", {31'd0, i_rvalid}, 32'd1);
                $display("[TB] starve cycle %0d gnt(i,d)=%0d%0d", c, i_gnt, d_gnt);
            end
            @(negedge clk);
            i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 1;
            #1;
            chk("st_last_rvalid", {31'd0, d_rvalid}, 32'd1);
            @(negedge clk);
            m_rvalid = 0;
        end

        // Boot mode: L exclusive for 10 transactions
        boot_mode = 1;
        i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h100; d_we = 4'h0;
        l_req = 1; l_addr = 32'h200; l_we = 4'hF; l_wdata = 32'h0BAD_F00D;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            m_gnt = 1; m_rvalid = 0;
            #1;
            chk("bt_gnt", {29'd0, i_gnt, d_gnt, l_gnt}, 32'd1);
            chk("bt_maddr", m_addr, 32'h200);
            @(negedge clk);
            m_rvalid = 1;
            #1;
            chk("bt_rvalid", {29'd0, i_rvalid, d_rvalid, l_rvalid}, 32'd1);
            $display("[TB] boot txn %0d l_gnt/l_rvalid seen", k);
        end
        @(negedge clk);
        m_gnt = 1; m_rvalid = 0;
        #1;
        chk("bt_last_lgnt", {31'd0, l_gnt}, 32'd1);
        @(negedge clk);
        boot_mode = 0;
        #1;
        chk("bt_drop_mreq", {31'd0, m_req}, 32'd0);
        chk("bt_drop_gnts", {29'd0, i_gnt, d_gnt, l_gnt}, 32'd0);
        @(negedge clk);
        m_rvalid = 1;
        #1;
        chk("bt_drop_lrvalid", {31'd0, l_rvalid}, 32'd1);
        @(negedge clk);
        m_rvalid = 0; l_req = 0;
        #1;
        chk("bt_next_dgnt", {31'd0, d_gnt}, 32'd1);
        chk("bt_next_others", {30'd0, i_gnt, l_gnt}, 32'd0);
        chk("bt_next_maddr", m_addr, 32'h100);
        @(negedge clk);
        i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 1;
        #1;
        chk("bt_next_drvalid", {31'd0, d_rvalid}, 32'd1);
        @(negedge clk);
        m_rvalid = 0;
        $display("[TB] boot_mode drop mid-WAIT done");

        // Spurious response while IDLE
        @(negedge clk);
        m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
        #1;
        chk("sp_rvalids", {29'd0, i_rvalid, d_rvalid, l_rvalid}, 32'd0);
        chk("sp_irdata", i_rdata, 32'd0);
        @(negedge clk);
        m_rvalid = 0;
        #1;
        chk("sp_err", {31'd0, err}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("sp_err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        #1;
        chk("sp_err_cleared", {31'd0, err}, 32'd0);
        $display("[TB] spurious m_rvalid handled");

        // Reset during WAIT drops the transaction
        @(negedge clk);
        d_req = 1; d_addr = 32'h444; d_we = 4'h1; d_wdata = 32'h77; m_gnt = 1;
        #1;
        chk("rw_dgnt", {31'd0, d_gnt}, 32'd1);
        @(negedge clk);
        #2;
        reset = 0; m_rvalid = 1;
        #1;
        chk("rw_mreq", {31'd0, m_req}, 32'd0);
        chk("rw_maddr", m_addr, 32'd0);
        chk("rw_flags", {26'd0, i_gnt, d_gnt, l_gnt, i_rvalid, d_rvalid, l_rvalid}, 32'd0);
        chk("rw_drdata", d_rdata, 32'd0);
        @(negedge clk);
        m_rvalid = 0; reset = 1;
        #1;
        chk("rw_regrant", {31'd0, d_gnt}, 32'd1);
        chk("rw_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h99;
        #1;
        chk("rw_drvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rw_drdata2", d_rdata, 32'h99);
        @(negedge clk);
        idle_inputs();
        $display("[TB] reset mid-WAIT recovered");

        // Randomized traffic against a transaction-level model
        busy_m = 0; rp = 0; wait_i = 0; rcd = 0; own_m = 0; ntx = 0;
        drop_i = 0; drop_d = 0; drop_l = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (drop_i) i_req = 0;
            if (drop_d) d_req = 0;
            if (drop_l) l_req = 0;
            drop_i = 0; drop_d = 0; drop_l = 0;
            if ($urandom_range(0, 39) == 0) boot_mode = ~boot_mode;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1; d_addr = $urandom; d_wdata = $urandom;
                d_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end
            if (!l_req && $urandom_range(0, 2) == 0) begin
                l_req = 1; l_addr = $urandom; l_wdata = $urandom; l_we = 4'($urandom);
            end
            m_gnt = ($urandom_range(0, 3) != 0);
            m_rvalid = rp && (rcd == 0);
            m_rdata = $urandom;
            #1;
            who = 0; e_g = 3'b000; e_r = 3'b000; e_mreq = 0;
            e_addr = '0; e_we = '0; e_wd = '0; e_ird = '0; e_drd = '0;
            if (!busy_m) begin
                if (boot_mode) begin
                    if (l_req) who = 3;
                end else if (i_req && wait_i >= MAX_WAIT) who = 1;
                else if (d_req) who = 2;
                else if (i_req) who = 1;
                if (who == 1) e_addr = i_addr;
                if (who == 2) begin e_addr = d_addr; e_we = d_we; e_wd = d_wdata; end
                if (who == 3) begin e_addr = l_addr; e_we = l_we; e_wd = l_wdata; end
                e_mreq = (who != 0);
                if (who != 0 && m_gnt) e_g = 3'b100 >> (who - 1);
            end else if (m_rvalid) begin
                e_r = 3'b100 >> (own_m - 1);
                if (own_m == 1) e_ird = m_rdata;
                if (own_m == 2) e_drd = m_rdata;
            end
            chk("rnd_mreq", {31'd0, m_req}, {31'd0, e_mreq});
            chk("rnd_maddr", m_addr, e_addr);
            chk("rnd_mwe", {28'd0, m_we}, {28'd0, e_we});
            chk("rnd_mwdata", m_wdata, e_wd);
            chk("rnd_gnt", {29'd0, i_gnt, d_gnt, l_gnt}, {29'd0, e_g});
            chk("rnd_rvalid", {29'd0, i_rvalid, d_rvalid, l_rvalid}, {29'd0, e_r});
            chk("rnd_irdata", i_rdata, e_ird);
            chk("rnd_drdata", d_rdata, e_drd);
            if (boot_mode || !i_req || e_g[2]) wait_i = 0;
            else if (wait_i < 15) wait_i++;
            if (!busy_m && e_g != 3'b000) begin
                busy_m = 1; own_m = who; rp = 1; rcd = $urandom_range(0, 2);
                drop_i = (who == 1); drop_d = (who == 2); drop_l = (who == 3);
                ntx++;
                $display("[TB] rnd txn %0d owner=%0d addr=%h we=%h", ntx, who, e_addr, e_we);
            end else if (busy_m && m_rvalid) begin
                busy_m = 0; rp = 0;
            end else if (rp) begin
                rcd--;
            end
        end
        @(negedge clk);
        #1;
        chk("rnd_err", {31'd0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
